// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
// uart_rx_pkg
//   Shared definitions for the RS-232 receiver (and its transmitter partner):
//   3-bit FSM state encodings, the start/stop line levels, and a 2-of-3
//   majority helper used when UART_RX_MAJORITY_EN is defined.
//   No ports (package).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
`timescale 1ns/1ps
// uart_sync2
//   Two-flop synchroniser for an asynchronous single-bit input.
//   Both stages reset to RST_VAL so the synchronised value starts at the
//   line's idle level.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronised output (2 clocks of latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
//   RS-232 receiver: 8 data bits, LSB first, one stop bit, no parity.
//   Bit timing is generated internally from CLK_FREQ / BAUD; the start bit is
//   confirmed at its centre and each following bit is sampled one bit period
//   later. A low stop bit raises frame_err and parks the FSM in BREAK until
//   the line returns high, so a held-low line cannot retrigger reception.
//   Optional build macro UART_RX_MAJORITY_EN: every sample becomes the 2-of-3
//   majority of the synchronised line around the sample point, decided one
//   clock later than the single-sample build.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rs232_rx   in   asynchronous serial line, idles high
//   rx_data    out  last correctly framed byte, held until the next good frame
//   rx_valid   out  one-cycle strobe, rx_data updated in the same cycle
//   frame_err  out  one-cycle strobe when the stop bit is sampled low
//   rx_busy    out  high whenever the FSM is not in IDLE
// Handshake: rx_valid is a pure strobe with no ready/backpressure; a consumer
//   must capture rx_data in the cycle rx_valid is high (it then holds anyway).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  logic            bit_sample;
  uart_state_t     state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rs232_rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The start decision moves one clock later so its three samples straddle
  // the half-bit point; every later decision then inherits that one-clock
  // shift without changing the per-bit counter limit.
  localparam logic [CW-1:0] START_LAST = CW'(HALF_BIT);

  logic [1:0] rx_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_hist <= 2'b11;
    else     rx_hist <= {rx_hist[0], rx_s};
  end

  always_comb begin
    bit_sample = maj3(rx_hist[1], rx_hist[0], rx_s);
  end
`else
  localparam logic [CW-1:0] START_LAST = CW'(HALF_BIT - 1);

  always_comb begin
    bit_sample = rx_s;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (rx_s == START_BIT) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == START_LAST) begin
            baud_cnt <= '0;
            if (bit_sample == START_BIT) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Line was already high again at mid-bit: treat as a glitch.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {bit_sample, shift_reg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_sample == STOP_BIT) begin
              // Leaving at mid-stop-bit lets a start bit follow immediately.
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        BREAK: begin
          baud_cnt <= '0;
          if (rx_s == STOP_BIT) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
